// File: rtl/jk_bank_sequencer.sv
// rtl/jk_bank_sequencer.sv - command sequencer driving a bank of JK flip-flops
module jk_bank_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_mask,
    input  logic [CNT_W-1:0] cmd_count,
    output logic [WIDTH-1:0] j_bus,
    output logic [WIDTH-1:0] k_bus,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] OP_HOLD   = 2'b00;
    localparam logic [1:0] OP_SET    = 2'b01;
    localparam logic [1:0] OP_CLEAR  = 2'b10;
    localparam logic [1:0] OP_TOGGLE = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       op_r;
    logic [WIDTH-1:0] mask_r;
    logic [CNT_W-1:0] rem;
    logic             accept;
    logic             toggle_cmd;

    assign accept     = cmd_valid & cmd_ready;
    assign toggle_cmd = (cmd_op == OP_TOGGLE);

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        j_bus     = '0;
        k_bus     = '0;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                case (op_r)
                    OP_SET:    j_bus = mask_r;
                    OP_CLEAR:  k_bus = mask_r;
                    OP_TOGGLE: begin
                        j_bus = mask_r;
                        k_bus = mask_r;
                    end
                    default: ;
                endcase
                // rem==0 cannot occur here; treated as last cycle so the FSM can never stall
                if (rem <= CNT_W'(1)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            q      <= '0;
            rem    <= '0;
            op_r   <= OP_HOLD;
            mask_r <= '0;
        end else begin
            state <= state_nxt;
            q     <= (j_bus & ~q) | (~k_bus & q);
            if (accept) begin
                // a zero-length toggle runs as a one-cycle HOLD so J/K stay low
                op_r   <= (toggle_cmd && cmd_count == '0) ? OP_HOLD : cmd_op;
                mask_r <= cmd_mask;
                rem    <= (toggle_cmd && cmd_count != '0) ? cmd_count : CNT_W'(1);
            end else if (state == S_EXEC && rem != '0) begin
                rem <= rem - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// tb/tb_jk_bank_sequencer.sv - directed self-checking bench for jk_bank_sequencer
module tb_jk_bank_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_mask;
    logic [3:0] cmd_count;
    logic [7:0] j_bus;
    logic [7:0] k_bus;
    logic [7:0] q;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    jk_bank_sequencer #(.WIDTH(8), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_mask  (cmd_mask),
        .cmd_count (cmd_count),
        .j_bus     (j_bus),
        .k_bus     (k_bus),
        .q         (q),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input logic [1:0] op, input logic [7:0] mask, input logic [3:0] cnt);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_mask  = mask;
        cmd_count = cnt;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive_cmd(2'b01, 8'hFF, 4'd0);
        tick;
        tick;
        n_checks++; if (q !== 8'h00) begin n_fail++; $display("FAIL reset_q: got %h want 00", q); end
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if ({j_bus, k_bus} !== 16'h0000) begin n_fail++; $display("FAIL reset_jk: got %h want 0000", {j_bus, k_bus}); end
        cmd_valid = 1'b0;
        rst = 1'b0;
        tick;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_no_accept: busy got %b want 0", busy); end
    endtask

    task automatic test_set;
        drive_cmd(2'b01, 8'hA5, 4'd7);
        tick;
        cmd_valid = 1'b0;
        n_checks++; if (j_bus !== 8'hA5 || k_bus !== 8'h00) begin n_fail++; $display("FAIL set_jk: got j=%h k=%h want j=a5 k=00", j_bus, k_bus); end
        n_checks++; if (busy !== 1'b1 || cmd_ready !== 1'b0) begin n_fail++; $display("FAIL set_busy: got busy=%b ready=%b want 1/0", busy, cmd_ready); end
        n_checks++; if (q !== 8'h00) begin n_fail++; $display("FAIL set_q_e0: got %h want 00", q); end
        tick;
        n_checks++; if (q !== 8'hA5) begin n_fail++; $display("FAIL set_q: got %h want a5", q); end
        n_checks++; if (done !== 1'b1 || cmd_ready !== 1'b0) begin n_fail++; $display("FAIL set_done: got done=%b ready=%b want 1/0", done, cmd_ready); end
        n_checks++; if ({j_bus, k_bus} !== 16'h0000) begin n_fail++; $display("FAIL set_jk_done: got %h want 0000", {j_bus, k_bus}); end
        tick;
        n_checks++; if (done !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL set_idle: got done=%b ready=%b busy=%b want 0/1/0", done, cmd_ready, busy); end
    endtask

    task automatic test_clear;
        drive_cmd(2'b10, 8'h0F, 4'd0);
        tick;
        cmd_valid = 1'b0;
        n_checks++; if (j_bus !== 8'h00 || k_bus !== 8'h0F) begin n_fail++; $display("FAIL clear_jk: got j=%h k=%h want j=00 k=0f", j_bus, k_bus); end
        tick;
        n_checks++; if (q !== 8'hA0) begin n_fail++; $display("FAIL clear_q: got %h want a0", q); end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL clear_done: got %b want 1", done); end
        tick;
        n_checks++; if (done !== 1'b0 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL clear_idle: got done=%b ready=%b want 0/1", done, cmd_ready); end
    endtask

    task automatic test_toggle;
        logic [7:0] exp_q [0:4];
        logic       exp_busy [0:4];
        int         dones;
        exp_q    = '{8'hA0, 8'h5F, 8'hA0, 8'h5F, 8'h5F};
        exp_busy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        dones = 0;
        drive_cmd(2'b11, 8'hFF, 4'd3);
        for (int i = 0; i < 5; i++) begin
            tick;
            cmd_valid = 1'b0;
            if (done === 1'b1) dones++;
            n_checks++; if (q !== exp_q[i]) begin n_fail++; $display("FAIL toggle_q[%0d]: got %h want %h", i, q, exp_q[i]); end
            n_checks++; if (busy !== exp_busy[i]) begin n_fail++; $display("FAIL toggle_busy[%0d]: got %b want %b", i, busy, exp_busy[i]); end
            if (i < 3) begin
                n_checks++; if (j_bus !== 8'hFF || k_bus !== 8'hFF) begin n_fail++; $display("FAIL toggle_jk[%0d]: got j=%h k=%h want ff/ff", i, j_bus, k_bus); end
            end
        end
        n_checks++; if (dones !== 1) begin n_fail++; $display("FAIL toggle_done_count: got %0d want 1", dones); end
        drive_cmd(2'b11, 8'hFF, 4'd0);
        tick;
        cmd_valid = 1'b0;
        n_checks++; if ({j_bus, k_bus} !== 16'h0000 || busy !== 1'b1) begin n_fail++; $display("FAIL toggle0_jk: got jk=%h busy=%b want 0000/1", {j_bus, k_bus}, busy); end
        tick;
        n_checks++; if (q !== 8'h5F || done !== 1'b1) begin n_fail++; $display("FAIL toggle0_done: got q=%h done=%b want 5f/1", q, done); end
        tick;
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL toggle0_idle: got %b want 1", cmd_ready); end
    endtask

    task automatic test_handshake;
        int dones;
        dones = 0;
        drive_cmd(2'b10, 8'hFF, 4'd0);
        tick;
        cmd_valid = 1'b0;
        tick;
        tick;
        n_checks++; if (q !== 8'h00) begin n_fail++; $display("FAIL hs_clear_all: got %h want 00", q); end
        drive_cmd(2'b11, 8'hFE, 4'd2);
        tick;
        drive_cmd(2'b01, 8'h01, 4'd9);
        tick;
        n_checks++; if (q !== 8'hFE) begin n_fail++; $display("FAIL hs_tog_q1: got %h want fe", q); end
        tick;
        n_checks++; if (q !== 8'h00 || done !== 1'b1) begin n_fail++; $display("FAIL hs_tog_q2: got q=%h done=%b want 00/1", q, done); end
        tick;
        n_checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0 || q !== 8'h00) begin n_fail++; $display("FAIL hs_wait_idle: got ready=%b busy=%b q=%h want 1/0/00", cmd_ready, busy, q); end
        tick;
        cmd_valid = 1'b0;
        n_checks++; if (busy !== 1'b1 || j_bus !== 8'h01 || k_bus !== 8'h00) begin n_fail++; $display("FAIL hs_set_accept: got busy=%b j=%h k=%h want 1/01/00", busy, j_bus, k_bus); end
        for (int i = 0; i < 4; i++) begin
            tick;
            if (done === 1'b1) dones++;
        end
        n_checks++; if (q !== 8'h01) begin n_fail++; $display("FAIL hs_set_q: got %h want 01", q); end
        n_checks++; if (dones !== 1 || busy !== 1'b0) begin n_fail++; $display("FAIL hs_single_exec: got dones=%0d busy=%b want 1/0", dones, busy); end
    endtask

    task automatic test_reset_mid;
        logic [7:0] exp_q [0:3];
        exp_q = '{8'h0E, 8'h01, 8'h0E, 8'h01};
        drive_cmd(2'b11, 8'h0F, 4'd10);
        tick;
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick;
            n_checks++; if (q !== exp_q[i]) begin n_fail++; $display("FAIL mid_q[%0d]: got %h want %h", i, q, exp_q[i]); end
        end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        n_checks++; if (q !== 8'h00 || cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL mid_abort: got q=%h ready=%b busy=%b done=%b want 00/1/0/0", q, cmd_ready, busy, done); end
        tick;
        n_checks++; if (done !== 1'b0 || q !== 8'h00) begin n_fail++; $display("FAIL mid_no_done: got done=%b q=%h want 0/00", done, q); end
        drive_cmd(2'b01, 8'h80, 4'd0);
        tick;
        cmd_valid = 1'b0;
        tick;
        n_checks++; if (q !== 8'h80 || done !== 1'b1) begin n_fail++; $display("FAIL mid_set: got q=%h done=%b want 80/1", q, done); end
        tick;
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_mask  = 8'h00;
        cmd_count = 4'd0;
        test_reset;
        test_set;
        test_clear;
        test_toggle;
        test_handshake;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
